// File: rtl/phy_lane_fifo.sv
// Single-clock byte-lane FIFO for the DDR PHY datapath: 8x8 pass-through, 4x8 nibble
// packing or 8x4 nibble unpacking, with almost-flags, occupancy count and sticky errors.
module phy_lane_fifo #(
  parameter int CHANNELS  = 10,
  parameter int DEPTH     = 8,
  parameter int MODE      = 0,
  parameter int AE_THRESH = 1,
  parameter int AF_THRESH = 1
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         WREN,
  input  logic [CHANNELS*8-1:0]        D,
  input  logic                         RDEN,
  output logic [CHANNELS*8-1:0]        Q,
  output logic                         EMPTY,
  output logic                         FULL,
  output logic                         ALMOSTEMPTY,
  output logic                         ALMOSTFULL,
  output logic [$clog2(DEPTH+1)-1:0]   COUNT,
  input  logic                         CLR_ERR,
  output logic                         OVERFLOW,
  output logic                         UNDERFLOW
);

  localparam int W  = CHANNELS * 8;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [W-1:0] LO_MASK = {CHANNELS{8'h0F}};

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d, remain;
  logic          wph_q, wph_d, rph_q, rph_d;
  logic [W-1:0]  stage_q, stage_d, q_q, q_d;
  logic          ovf_q, ovf_d, unf_q, unf_d;
  logic          empty, full, acc_wr, acc_rd, push, pop;
  logic [W-1:0]  push_data, head;

  // Request/accept: WREN/RDEN are requests sampled every edge; a write is taken when
  // !FULL and a read when !EMPTY (both from registered COUNT), refused ones only flag errors.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CW'(DEPTH));
    acc_wr    = WREN & ~full;
    acc_rd    = RDEN & ~empty;
    push      = acc_wr & ((MODE != 1) | wph_q);
    pop       = acc_rd & ((MODE != 2) | rph_q);
    push_data = (MODE == 1) ? (((D & LO_MASK) << 4) | stage_q) : D;

    wph_d   = (MODE == 1) ? (wph_q ^ acc_wr) : 1'b0;
    rph_d   = (MODE == 2) ? (rph_q ^ acc_rd) : 1'b0;
    stage_d = stage_q;
    if ((MODE == 1) && acc_wr && !wph_q) stage_d = D & LO_MASK;

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);

    // Next head comes from the bypass when the FIFO drains to zero this edge.
    remain = count_q - CW'(pop);
    head   = (remain == '0) ? push_data : mem_q[rd_ptr_d];
    if (MODE == 2) head = rph_d ? ((head >> 4) & LO_MASK) : (head & LO_MASK);
    q_d = (count_d != '0) ? head : q_q;

    ovf_d = (ovf_q & ~CLR_ERR) | (WREN & full);
    unf_d = (unf_q & ~CLR_ERR) | (RDEN & empty);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wph_q    <= 1'b0;
      rph_q    <= 1'b0;
      stage_q  <= '0;
      q_q      <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wph_q    <= wph_d;
      rph_q    <= rph_d;
      stage_q  <= stage_d;
      q_q      <= q_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && push) mem_q[wr_ptr_q] <= push_data;
  end

  assign Q           = q_q;
  assign COUNT       = count_q;
  assign EMPTY       = empty;
  assign FULL        = full;
  assign ALMOSTEMPTY = (count_q <= CW'(AE_THRESH));
  assign ALMOSTFULL  = (count_q >= CW'(DEPTH - AF_THRESH));
  assign OVERFLOW    = ovf_q;
  assign UNDERFLOW   = unf_q;

endmodule

// File: tb/tb_phy_lane_fifo.sv
// Four phy_lane_fifo configurations driven by shared stimulus and compared each cycle
// against a queue-based reference model, plus directed constant checks.
module tb_phy_lane_fifo;

  localparam int NI = 4;
  localparam int MODE_P  [NI] = '{0, 1, 2, 0};
  localparam int DEPTH_P [NI] = '{8, 8, 8, 4};
  localparam int AE_P    [NI] = '{1, 1, 1, 2};
  localparam int AF_P    [NI] = '{1, 1, 1, 2};
  localparam logic [31:0] LO = 32'h0F0F_0F0F;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, wren, rden, clr;
  logic [31:0] d;
  logic [31:0] q_o   [NI];
  logic [3:0]  cnt_o [NI];
  logic [5:0]  fl_o  [NI];  // {ovf, unf, af, ae, full, empty}

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int DP = DEPTH_P[g];
    logic [$clog2(DP+1)-1:0] c;
    logic e, f, ae, af, ov, un;
    phy_lane_fifo #(.CHANNELS(4), .DEPTH(DP), .MODE(MODE_P[g]),
                    .AE_THRESH(AE_P[g]), .AF_THRESH(AF_P[g])) u_dut (
      .CLK(clk), .RESET(rst), .WREN(wren), .D(d), .RDEN(rden), .Q(q_o[g]),
      .EMPTY(e), .FULL(f), .ALMOSTEMPTY(ae), .ALMOSTFULL(af), .COUNT(c),
      .CLR_ERR(clr), .OVERFLOW(ov), .UNDERFLOW(un)
    );
    assign cnt_o[g] = 4'(c);
    assign fl_o[g]  = {ov, un, af, ae, f, e};
  end

  // reference model
  logic [31:0] exp_q [NI][$];
  logic        mwph [NI], mrph [NI], movf [NI], munf [NI];
  logic [31:0] mstage [NI], mq [NI];

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [31:0] fmt(int k, logic [31:0] h);
    if (MODE_P[k] != 2) return h;
    return mrph[k] ? ((h >> 4) & LO) : (h & LO);
  endfunction

  task automatic model_step();
    for (int k = 0; k < NI; k++) begin
      logic full, empty, acc_wr, acc_rd, push, pop;
      logic [31:0] ent;
      full   = (exp_q[k].size() == DEPTH_P[k]);
      empty  = (exp_q[k].size() == 0);
      acc_wr = wren && !full;
      acc_rd = rden && !empty;
      push   = acc_wr && (MODE_P[k] != 1 || mwph[k]);
      pop    = acc_rd && (MODE_P[k] != 2 || mrph[k]);
      ent    = (MODE_P[k] == 1) ? (((d & LO) << 4) | mstage[k]) : d;
      if (rst) begin
        exp_q[k].delete();
        mwph[k] = 0; mrph[k] = 0; movf[k] = 0; munf[k] = 0;
        mstage[k] = '0; mq[k] = '0;
      end else begin
        if (acc_wr && MODE_P[k] == 1) begin
          if (!mwph[k]) mstage[k] = d & LO;
          mwph[k] = !mwph[k];
        end
        if (acc_rd && MODE_P[k] == 2) mrph[k] = !mrph[k];
        if (pop) void'(exp_q[k].pop_front());
        if (push) exp_q[k].push_back(ent);
        movf[k] = (movf[k] && !clr) || (wren && full);
        munf[k] = (munf[k] && !clr) || (rden && empty);
        if (exp_q[k].size() > 0) mq[k] = fmt(k, exp_q[k][0]);
      end
    end
  endtask

  // scoreboard
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NI; k++) begin
      int n;
      logic [5:0] ef;
      n  = exp_q[k].size();
      ef = {movf[k], munf[k], n >= DEPTH_P[k] - AF_P[k], n <= AE_P[k], n == DEPTH_P[k], n == 0};
      chk($sformatf("q[%0d]", k), q_o[k], mq[k]);
      chk($sformatf("count[%0d]", k), 32'(cnt_o[k]), 32'(n));
      chk($sformatf("flags[%0d]", k), 32'(fl_o[k]), 32'(ef));
    end
  endtask

  // driver
  task automatic step(input logic w, input logic r, input logic [31:0] dd,
                      input logic c, input logic rs);
    wren = w; rden = r; d = dd; clr = c; rst = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic wr(input logic [31:0] dd);
    step(1'b1, 1'b0, dd, 1'b0, 1'b0);
  endtask

  task automatic rd();
    step(1'b0, 1'b1, $urandom, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1; wren = 1'b0; rden = 1'b0; clr = 1'b0; d = '0;
    @(negedge clk);
    do_reset();
    do_reset();
    chk("rst_q", q_o[0], 32'h0);
    chk("rst_flags", 32'(fl_o[0]), 32'h05);

    // fill the 8-deep pass-through FIFO, overflow, drain in order
    for (int k = 1; k <= 8; k++) begin
      wr({4{8'(k)}});
      chk("fill_count", 32'(cnt_o[0]), 32'(k));
      if (k == 7) chk("af_at7", 32'(fl_o[0][3]), 32'h1);
    end
    chk("full_at8", 32'(fl_o[0][1]), 32'h1);
    wr(32'hEEEE_EEEE);
    chk("ovf_9th", 32'(fl_o[0][5]), 32'h1);
    for (int k = 1; k <= 8; k++) begin
      chk("drain_q", q_o[0], {4{8'(k)}});
      rd();
    end
    chk("drain_empty", 32'(fl_o[0][0]), 32'h1);
    do_reset();

    // nibble packing: upper nibbles of D are ignored
    wr(32'hFAFA_FAFA);
    chk("pack_count0", 32'(cnt_o[1]), 32'h0);
    wr(32'h3535_3535);
    chk("pack_count1", 32'(cnt_o[1]), 32'h1);
    chk("pack_q", q_o[1], 32'h5A5A_5A5A);
    do_reset();

    // nibble unpacking
    wr(32'hC3C3_C3C3);
    chk("unpack_lo", q_o[2], 32'h0303_0303);
    rd();
    chk("unpack_hi", q_o[2], 32'h0C0C_0C0C);
    chk("unpack_half_count", 32'(cnt_o[2]), 32'h1);
    rd();
    chk("unpack_done_count", 32'(cnt_o[2]), 32'h0);
    do_reset();

    // simultaneous push/pop at COUNT=4
    for (int k = 0; k < 4; k++) wr($urandom);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, 1'b1, $urandom, 1'b0, 1'b0);
      chk("sim_count", 32'(cnt_o[0]), 32'h4);
    end
    for (int k = 0; k < 4; k++) rd();
    do_reset();

    // read and write together while empty
    step(1'b1, 1'b1, 32'h1234_5678, 1'b0, 1'b0);
    chk("rw_empty_unf", 32'(fl_o[0][4]), 32'h1);
    chk("rw_empty_count", 32'(cnt_o[0]), 32'h1);
    do_reset();

    // pointer wrap on the 4-deep instance
    for (int k = 0; k < 20; k++) begin
      wr($urandom);
      rd();
    end
    do_reset();

    // reset in the middle of a nibble pack
    wr(32'h0101_0101);
    do_reset();
    chk("midrst_q", q_o[1], 32'h0);
    chk("midrst_flags", 32'(fl_o[1]), 32'h05);
    wr(32'h0707_0707);
    wr(32'h0909_0909);
    chk("midrst_pack", q_o[1], 32'h9797_9797);
    do_reset();

    // clear racing a new overflow
    for (int k = 0; k < 4; k++) wr($urandom);
    step(1'b1, 1'b0, $urandom, 1'b1, 1'b0);
    chk("clr_vs_ovf", 32'(fl_o[3][5]), 32'h1);
    step(1'b0, 1'b0, '0, 1'b1, 1'b0);
    chk("clr_ovf", 32'(fl_o[3][5]), 32'h0);

    // randomized traffic
    for (int k = 0; k < 400; k++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
           ($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/phy_lane_fifo.md
# phy_lane_fifo

Parametrised, synthesizable single-clock replacement for the PHY byte-lane IN/OUT FIFO primitives. It is used in simulation and non-Xilinx builds of the DDR PHY datapath. It provides a configurable channel count and depth, plus three array modes: 8-bit pass-through, 4-to-8 nibble packing and 8-to-4 nibble unpacking. It also adds programmable almost-flags, an occupancy count and sticky overflow/underflow error reporting. It sits between the PHY control logic and the SERDES lanes.

## Interface
- CHANNELS, 10, number of independent 8-bit lane channels sharing one set of pointers and flags.
- DEPTH, 8, storage entries; power of two, minimum 4.
- MODE, 0, 0 = 8X8 pass-through, 1 = 4X8 (write nibbles, read bytes), 2 = 8X4 (write bytes, read nibbles).
- AE_THRESH, 1, ALMOSTEMPTY asserted when COUNT <= AE_THRESH.
- AF_THRESH, 1, ALMOSTFULL asserted when COUNT >= DEPTH-AF_THRESH.

Ports:
- CLK  in  1  single clock; all state updates on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- WREN  in  1  write request.
- D  in  CHANNELS*8  write data; channel c at D[c*8+7:c*8]. In MODE 1 only D[c*8+3:c*8] is used.
- RDEN  in  1  read request.
- Q  out  CHANNELS*8  head data. In MODE 2, Q[c*8+7:c*8+4] = 0.
- EMPTY  out  1  COUNT == 0.
- FULL  out  1  COUNT == DEPTH.
- ALMOSTEMPTY  out  1  threshold flag.
- ALMOSTFULL  out  1  threshold flag.
- COUNT  out  $clog2(DEPTH+1)  number of complete stored entries.
- CLR_ERR  in  1  clears OVERFLOW and UNDERFLOW.
- OVERFLOW  out  1  sticky; a write was attempted while FULL.
- UNDERFLOW  out  1  sticky; a read was attempted while EMPTY.

## Operation
- Storage: DEPTH x (CHANNELS*8) array, write pointer, read pointer and COUNT register. Pointers wrap modulo DEPTH.
- Accepted write = WREN & !FULL. Accepted read = RDEN & !EMPTY. Rejected requests change no data or pointers.
- MODE 0: each accepted write pushes D. Each accepted read pops the head.
- MODE 1: a write phase bit (wph) toggles on each accepted write.
  - wph=0: the low nibble of every channel goes to a staging register; nothing is pushed.
  - wph=1: the entry {D nibble, staged nibble} is pushed per channel; the first write forms the low nibble.
  - The staging register does not count in COUNT. Writes are rejected while FULL regardless of wph.
- MODE 2: a read phase bit (rph) toggles on each accepted read.
  - rph=0: Q shows the low nibble of the head.
  - rph=1: Q shows the high nibble of the head; the accepted read then pops the entry.
  - A half-read entry still counts in COUNT.
- Q is first-word-fall-through: it shows the formatted head whenever EMPTY=0. When EMPTY=1, Q holds its last value.
- Simultaneous accepted push and pop: COUNT is unchanged and both pointers advance.
- Simultaneous WREN & RDEN when FULL: the read (and its pop, if completing) is accepted, the write is rejected and OVERFLOW is set.
- Simultaneous WREN & RDEN when EMPTY: the write is accepted, the read is rejected and UNDERFLOW is set.
- CLR_ERR clears both sticky bits. An error occurring in the same cycle wins (the bit stays 1).
- Reset values:
  - pointers, COUNT, wph, rph, staging register, Q and the error bits are all 0;
  - EMPTY = 1, ALMOSTEMPTY = 1, FULL = 0, ALMOSTFULL = 0.
- RESET mid-operation discards all contents, including a half-packed nibble or a half-read entry.

## Timing
- All flags and COUNT are decoded combinationally from registered COUNT, so they reflect operations of the previous edge.
- Write to read latency: a push at edge N gives EMPTY=0 and valid Q after edge N. A read is accepted at edge N+1 at the earliest.
  - In MODE 1 this latency counts from the second nibble write.
- A pop at edge N presents the next head (or holds Q if now empty) after edge N.
- Full throughput: one accepted write and one accepted read per cycle, in any mode.
- No combinational path from WREN or RDEN to any output.

## Test plan
- MODE 0, DEPTH 8: 8 writes of 0x01..0x08 on all channels -> FULL=1, COUNT=8, ALMOSTFULL=1 from COUNT 7. A 9th write sets OVERFLOW. 8 reads return 0x01..0x08 in order, then EMPTY=1.
- MODE 1: write nibbles 0xA then 0x5 -> COUNT goes 0 then 1, and Q=0x5A on every channel one cycle after the second write.
- MODE 2: write 0xC3, then read twice -> Q=0x03 then 0x0C, COUNT drops to 0 only after the second read, and the upper nibble of Q is 0.
- Simultaneous: WREN & RDEN each cycle at COUNT=4 -> COUNT stays 4 and data stays FIFO-ordered. RDEN & WREN at EMPTY -> UNDERFLOW=1 and COUNT=1.
- Pointer wrap: 20 interleaved write/read pairs at DEPTH 4 -> output data sequence equals input sequence.
- Reset mid-MODE-1 pack (wph=1): after RESET, EMPTY=1, Q=0, errors 0, and the next two nibble writes form a fresh entry. Assert CLR_ERR together with a new overflow -> OVERFLOW stays 1.
